imem_fetch_ctrl: RTL and testbench

IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

---
 rtl/imem_fetch_ctrl.sv | 136 +++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_ctrl.sv
// rtl/imem_fetch_ctrl.sv - instruction-memory loader and fetch PC controller
// Loads program words into imem, then sequences pc through RUN until a zero word halts it.
module imem_fetch_ctrl #(
    parameter int IMEM_WORDS = 64,
    parameter int PC_W       = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load_valid,
    input  logic [31:0]     load_data,
    output logic            load_ready,
    input  logic            load_done,
    output logic            imem_we,
    output logic [5:0]      imem_waddr,
    output logic [31:0]     imem_wdata,
    output logic [PC_W-1:0] pc,
    input  logic [31:0]     instruction,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [15:0]     branch_off,
    input  logic            jump,
    input  logic [25:0]     jump_target,
    input  logic            restart,
    output logic            cpu_en,
    output logic            halted,
    output logic [15:0]     fetch_count
);

    localparam int WPTR_W = $clog2(IMEM_WORDS + 1);
    localparam logic [WPTR_W-1:0] WPTR_FULL = WPTR_W'(IMEM_WORDS);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_RUN,
        ST_HALT
    } state_t;

    state_t            state, state_nxt;
    logic [WPTR_W-1:0] wptr, wptr_nxt;
    logic [PC_W-1:0]   pc_q, pc_nxt;
    logic [15:0]       fc_q, fc_nxt;
    logic              armed;

    logic [31:0]        pc_ext;
    logic [31:0]        seq_addr;
    logic [31:0]        br_addr;
    logic [27:0]        jmp_addr;
    logic [WPTR_W+5:0]  wptr_ext;
    logic [15:0]        fc_inc;
    logic               load_full;

    // Target addresses are formed wide and truncated, giving modulo-2^PC_W wrap for free.
    assign pc_ext    = 32'(pc_q);
    assign seq_addr  = pc_ext + 32'd4;
    assign br_addr   = seq_addr + {{14{branch_off[15]}}, branch_off, 2'b00};
    assign jmp_addr  = {jump_target, 2'b00};
    assign wptr_ext  = {6'b0, wptr};
    assign fc_inc    = (fc_q == 16'hFFFF) ? fc_q : fc_q + 16'd1;
    assign load_full = (wptr >= WPTR_FULL);

    assign pc          = pc_q;
    assign fetch_count = fc_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_LOAD;
            wptr  <= '0;
            pc_q  <= '0;
            fc_q  <= '0;
            armed <= 1'b0;
        end else begin
            state <= state_nxt;
            wptr  <= wptr_nxt;
            pc_q  <= pc_nxt;
            fc_q  <= fc_nxt;
            armed <= 1'b1;
        end
    end

    always_comb begin
        state_nxt  = state;
        wptr_nxt   = wptr;
        pc_nxt     = pc_q;
        fc_nxt     = fc_q;
        load_ready = 1'b0;
        imem_we    = 1'b0;
        imem_waddr = wptr_ext[5:0];
        imem_wdata = load_data;
        cpu_en     = 1'b0;
        halted     = 1'b0;

        case (state)
            ST_LOAD: begin
                // armed keeps the loader quiet until the first edge out of reset
                load_ready = armed && !load_full;
                imem_we    = load_valid && load_ready;
                if (imem_we) begin
                    wptr_nxt = wptr + WPTR_W'(1);
                end
                if (load_done) begin
                    state_nxt = ST_RUN;
                    pc_nxt    = '0;
                end
            end
            ST_RUN: begin
                cpu_en = 1'b1;
                if (!stall) begin
                    if (instruction == 32'h0) begin
                        state_nxt = ST_HALT;
                    end else begin
                        fc_nxt = fc_inc;
                        if (jump) begin
                            pc_nxt = jmp_addr[PC_W-1:0];
                        end else if (branch_taken) begin
                            pc_nxt = br_addr[PC_W-1:0];
                        end else begin
                            pc_nxt = seq_addr[PC_W-1:0];
                        end
                    end
                end
            end
            ST_HALT: begin
                halted = 1'b1;
                if (restart) begin
                    state_nxt = ST_RUN;
                    pc_nxt    = '0;
                    fc_nxt    = '0;
                end
            end
            default: begin
                state_nxt = ST_LOAD;
            end
        endcase
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb/tb_imem_fetch_ctrl.sv - self-checking bench for imem_fetch_ctrl
module tb_imem_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_valid;
    logic [31:0] load_data;
    logic        load_ready;
    logic        load_done;
    logic        imem_we;
    logic [5:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic [7:0]  pc;
    logic [31:0] instruction;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_off;
    logic        jump;
    logic [25:0] jump_target;
    logic        restart;
    logic        cpu_en;
    logic        halted;
    logic [15:0] fetch_count;

    imem_fetch_ctrl #(.IMEM_WORDS(64), .PC_W(8)) dut (
        .clk(clk), .reset(reset),
        .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
        .load_done(load_done),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .pc(pc), .instruction(instruction), .stall(stall),
        .branch_taken(branch_taken), .branch_off(branch_off),
        .jump(jump), .jump_target(jump_target), .restart(restart),
        .cpu_en(cpu_en), .halted(halted), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int wr_seen  = 0;

    // Reference model: mode 0=load, 1=run, 2=halt
    int m_mode, m_pc, m_wptr, m_fc, m_edges;

    typedef struct {
        bit          stl;
        bit          br;
        logic [15:0] off;
        bit          jmp;
        logic [25:0] jt;
        logic [31:0] ins;
        bit          rs;
        bit          ld;
        int          e_pc;
        bit          e_halt;
        int          e_fc;
    } vec_t;

    vec_t tbl [19];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_pc = 0; m_wptr = 0; m_fc = 0; m_edges = 0;
    endtask

    task automatic model_edge(input bit we);
        int o;
        m_edges++;
        case (m_mode)
            0: begin
                if (we) m_wptr++;
                if (load_done) begin m_mode = 1; m_pc = 0; end
            end
            1: begin
                if (!stall) begin
                    if (instruction == 32'h0) begin
                        m_mode = 2;
                    end else begin
                        if (m_fc < 65535) m_fc++;
                        o = int'($signed(branch_off));
                        if (jump) m_pc = (int'(jump_target) * 4) % 256;
                        else if (branch_taken) m_pc = ((m_pc + 4 + 4 * o) % 256 + 256) % 256;
                        else m_pc = (m_pc + 4) % 256;
                    end
                end
            end
            default: begin
                if (restart) begin m_mode = 1; m_pc = 0; m_fc = 0; end
            end
        endcase
    endtask

    // Called at posedge+1 with inputs settled; checks, clocks, updates model.
    task automatic tick();
        bit elr, ewe;
        #3;
        elr = (m_mode == 0) && (m_edges >= 1) && (m_wptr < 64);
        ewe = elr && load_valid;
        chk("load_ready", 32'(load_ready), 32'(elr));
        chk("imem_we", 32'(imem_we), 32'(ewe));
        if (ewe) begin
            chk("imem_waddr", 32'(imem_waddr), 32'(m_wptr));
            chk("imem_wdata", imem_wdata, load_data);
        end
        if (imem_we) wr_seen++;
        chk("cpu_en", 32'(cpu_en), 32'(m_mode == 1));
        chk("halted", 32'(halted), 32'(m_mode == 2));
        chk("pc", 32'(pc), 32'(m_pc));
        chk("fetch_count", 32'(fetch_count), 32'(m_fc));
        @(posedge clk);
        model_edge(ewe);
        #1;
    endtask

    task automatic idle_inputs();
        load_valid = 0; load_data = 0; load_done = 0; instruction = 32'h1;
        stall = 0; branch_taken = 0; branch_off = 0; jump = 0; jump_target = 0;
        restart = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cpu_en"}, 32'(cpu_en), 32'd0);
        chk({tag, "_halted"}, 32'(halted), 32'd0);
        chk({tag, "_imem_we"}, 32'(imem_we), 32'd0);
        chk({tag, "_load_ready"}, 32'(load_ready), 32'd0);
        chk({tag, "_pc"}, 32'(pc), 32'd0);
        chk({tag, "_fetch_count"}, 32'(fetch_count), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{0, 0, 16'h0000, 0, 26'd0,  32'h1, 0, 0,   4, 0, 1};
        tbl[1]  = '{0, 0, 16'h0000, 0, 26'd0,  32'h1, 0, 0,   8, 0, 2};
        tbl[2]  = '{1, 0, 16'h0000, 0, 26'd0,  32'h0, 0, 0,   8, 0, 2};
        tbl[3]  = '{1, 1, 16'h0005, 0, 26'd0,  32'h0, 0, 0,   8, 0, 2};
        tbl[4]  = '{1, 0, 16'h0000, 1, 26'd3,  32'h0, 0, 0,   8, 0, 2};
        tbl[5]  = '{0, 0, 16'h0000, 1, 26'd8,  32'h1, 0, 0,  32, 0, 3};
        tbl[6]  = '{0, 1, 16'h0009, 0, 26'd0,  32'h1, 0, 0,  72, 0, 4};
        tbl[7]  = '{0, 0, 16'h0000, 1, 26'd8,  32'h1, 0, 0,  32, 0, 5};
        tbl[8]  = '{0, 1, 16'hFFFF, 0, 26'd0,  32'h1, 0, 0,  32, 0, 6};
        tbl[9]  = '{0, 0, 16'h0000, 1, 26'd63, 32'h1, 0, 0, 252, 0, 7};
        tbl[10] = '{0, 0, 16'h0000, 0, 26'd0,  32'h1, 0, 0,   0, 0, 8};
        tbl[11] = '{0, 1, 16'h0005, 1, 26'd31, 32'h1, 0, 0, 124, 0, 9};
        tbl[12] = '{0, 1, 16'h0001, 1, 26'd2,  32'h0, 0, 0, 124, 1, 9};
        tbl[13] = '{0, 0, 16'h0000, 1, 26'd2,  32'h1, 0, 0, 124, 1, 9};
        tbl[14] = '{0, 0, 16'h0000, 0, 26'd0,  32'h1, 0, 1, 124, 1, 9};
        tbl[15] = '{0, 0, 16'h0000, 0, 26'd0,  32'h1, 1, 0,   0, 0, 0};
        tbl[16] = '{0, 0, 16'h0000, 0, 26'd0,  32'h1, 1, 0,   4, 0, 1};
        tbl[17] = '{0, 0, 16'h0000, 0, 26'd0,  32'h1, 0, 1,   8, 0, 2};
        tbl[18] = '{0, 0, 16'h0000, 1, 26'h3FFFFC1, 32'h1, 0, 0, 4, 0, 3};

        idle_inputs();
        reset = 1;
        model_reset();
        load_valid = 1;
        #2;
        check_reset_outputs("por");
        load_valid = 0;
        @(posedge clk); @(posedge clk); #1;
        reset = 0;

        // Load 30 words, then end the load phase.
        tick();
        for (int i = 0; i < 30; i++) begin
            load_valid = 1;
            load_data  = 32'hC0DE0000 ^ (32'(i) * 32'h01010101);
            tick();
        end
        load_valid = 0;
        load_done  = 1;
        tick();
        load_done = 0;
        chk("load30_writes", 32'(wr_seen), 32'd30);
        chk("load30_run", 32'(cpu_en), 32'd1);
        chk("load30_pc", 32'(pc), 32'd0);

        // Directed RUN/HALT vectors.
        for (int i = 0; i < 19; i++) begin
            stall = tbl[i].stl; branch_taken = tbl[i].br; branch_off = tbl[i].off;
            jump = tbl[i].jmp; jump_target = tbl[i].jt; instruction = tbl[i].ins;
            restart = tbl[i].rs; load_done = tbl[i].ld;
            tick();
            chk($sformatf("vec%0d_pc", i), 32'(pc), 32'(tbl[i].e_pc));
            chk($sformatf("vec%0d_halted", i), 32'(halted), 32'(tbl[i].e_halt));
            chk($sformatf("vec%0d_cpu_en", i), 32'(cpu_en), 32'(!tbl[i].e_halt));
            chk($sformatf("vec%0d_fc", i), 32'(fetch_count), 32'(tbl[i].e_fc));
        end
        idle_inputs();

        // Asynchronous reset mid-run at pc=40.
        jump = 1; jump_target = 26'd10;
        tick();
        jump = 0;
        chk("pre_reset_pc", 32'(pc), 32'd40);
        #2;
        reset = 1;
        #1;
        check_reset_outputs("async");
        model_reset();
        @(posedge clk); #1;
        reset = 0;

        // Fill all 64 words, then offer a 65th.
        tick();
        wr_seen = 0;
        for (int i = 0; i < 64; i++) begin
            load_valid = 1;
            load_data  = 32'h0BAD0000 + 32'(i);
            tick();
        end
        load_data = 32'hDEADBEEF;
        #3;
        chk("full_load_ready", 32'(load_ready), 32'd0);
        chk("full_imem_we", 32'(imem_we), 32'd0);
        #0;
        @(posedge clk); model_edge(1'b0); #1;
        load_done = 1;
        tick();
        load_valid = 0; load_done = 0;
        chk("full_writes", 32'(wr_seen), 32'd64);
        chk("full_run", 32'(cpu_en), 32'd1);

        // Randomized run against the model.
        for (int n = 0; n < 400; n++) begin
            stall        = ($urandom % 4) == 0;
            branch_taken = ($urandom % 3) == 0;
            branch_off   = 16'($urandom);
            jump         = ($urandom % 5) == 0;
            jump_target  = 26'($urandom);
            instruction  = (($urandom % 12) == 0) ? 32'h0 : ($urandom | 32'h1);
            restart      = ($urandom % 3) == 0;
            load_done    = ($urandom % 7) == 0;
            load_valid   = ($urandom % 2) == 0;
            load_data    = $urandom;
            tick();
        end
        idle_inputs();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
